ws2811_stream_encoder: RTL and testbench
========================================

# ws2811_stream_encoder

Parametrised WS2811/WS2812 serial encoder. It accepts pixel bytes over a valid/ready handshake and emits the single-wire NRZ waveform: MSB-first, one high-then-low cell per bit. It counts bytes per frame and inserts the latch (reset) gap automatically. It sits between the USB-FIFO read side and the `ws2811` output pin, runs in the `clk` domain, and replaces the fixed 4-slot bit pattern and free-running 3-bit mux with cycle-exact, configurable timing and explicit underrun handling.

## Interface
- `T_BIT`, 16: clk cycles per bit cell (16 at 12.8 MHz = 1.25 us).
- `T0H`, 4: high cycles for a 0 bit.
- `T1H`, 12: high cycles for a 1 bit.
- `LATCH_CYCLES`, 640: low cycles of the end-of-frame latch gap (50 us at 12.8 MHz).
- `BYTES_PER_FRAME`, 90: bytes per frame (30 LEDs x 3 colours).
- Legal values: 0 < T0H < T1H < T_BIT, LATCH_CYCLES >= 1, BYTES_PER_FRAME >= 1. Elaboration fails otherwise.

Ports:
- `clk`  in  1  sole clock. All state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_data`  in  8  pixel byte, GRB order as supplied by the host.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  a byte is accepted on any edge with `in_valid & in_ready`.
- `ws2811`  out  1  registered serial output to the strip.
- `busy`  out  1  high in SEND or LATCH.
- `frame_done`  out  1  one-cycle pulse at the end of the latch gap.
- `underrun`  out  1  one-cycle pulse when a frame is aborted for lack of data.

## Operation
- Datapath:
  - 8-bit holding register `hold` with flag `hold_v`; `in_ready = ~hold_v`. The holding register accepts in every state, including LATCH.
  - 8-bit shift register `sh`.
  - Cycle counter `cyc` (0..T_BIT-1), bit index `bi` (7..0), byte counter `nb` (0..BYTES_PER_FRAME), latch counter `lc` (0..LATCH_CYCLES-1).
  - Counter widths are `$clog2` of their ranges; `nb` is sized for BYTES_PER_FRAME+1.
- States:
  - IDLE: `ws2811`=0. If `hold_v`, then `sh<=hold`, `hold_v<=0`, `bi<=7`, `cyc<=0`, `nb<=0`, go to SEND.
  - SEND: `ws2811` is high while `cyc < (sh[bi] ? T1H : T0H)`, otherwise low. `cyc` wraps at T_BIT-1. On wrap:
    - If `bi` > 0, decrement `bi`.
    - If `bi` == 0, the byte is finished and `nb` increments. Then, in priority order:
      - If `nb+1 == BYTES_PER_FRAME`, go to LATCH with `lc<=0`.
      - Else if `hold_v`, load `sh<=hold`, `hold_v<=0`, `bi<=7`, stay in SEND (gapless).
      - Else pulse `underrun`, go to LATCH (the frame is aborted and the strip latches partial data).
  - LATCH: `ws2811`=0. `lc` counts up. When `lc == LATCH_CYCLES-1`, pulse `frame_done` only if the frame completed (never after an underrun), then go to IDLE.
- Simultaneous events:
  - Accept and load on the same edge: the load empties `hold` and the accept refills it on that edge, so `hold_v` stays 1 with the new byte.
  - Byte count and underrun on the same edge: byte count wins, and `underrun` does not pulse.
- Reset (including mid-byte or mid-latch), effective on the edge:
  - State goes to IDLE.
  - `ws2811`, `busy`, `frame_done` and `underrun` go to 0.
  - `hold_v` goes to 0, discarding any pending byte.
  - All counters go to 0.
  - `in_ready` is 1 from the first cycle after reset.

## Timing
- Latency: byte accepted at edge E0 (IDLE, `hold` empty), then `ws2811` rises at edge E1. Exactly one cycle of latency.
- Bit cell durations:
  - Every cell is exactly T_BIT cycles.
  - A 1 bit is high for T1H cycles, then low for T_BIT-T1H.
  - A 0 bit is high for T0H cycles, then low for T_BIT-T0H.
- Back-to-back bytes: no extra cycles between bytes, provided the next byte is accepted before the edge that ends the last cycle of bit 0.
- Frame length: exactly BYTES_PER_FRAME*8*T_BIT cycles of SEND, then LATCH_CYCLES cycles low.
  - `frame_done` is asserted in the cycle after the last latch cycle (the IDLE entry edge).
  - A new frame can start one cycle after that.
- `busy` is registered together with the state: high from E1 through the last LATCH cycle.

## Test plan
- Defaults, BYTES_PER_FRAME=1, send 0xA5:
  - `ws2811` high-pulse widths are 12,4,12,4,4,12,4,12, each in a 16-cycle cell, first rise one cycle after acceptance.
  - Then 640 cycles low, then one `frame_done` pulse.
- BYTES_PER_FRAME=3, `in_valid` held high with 0xFF, 0x00, 0x81:
  - 384 contiguous SEND cycles with no gap between bytes.
  - `in_ready` low between accepts.
  - Exactly 3 accepts, then `frame_done`.
- BYTES_PER_FRAME=3, supply only 2 bytes:
  - `underrun` pulses once at the end of byte 2.
  - 640-cycle low gap follows, no `frame_done`, back in IDLE.
- Present the next frame's first byte during LATCH:
  - Accepted, so `in_ready` drops.
  - SEND begins on the edge after IDLE is entered and `frame_done` pulses.
- Assert `rst` for one cycle mid-bit while `hold_v`=1:
  - `ws2811`=0 and `busy`=0 next cycle, `in_ready`=1.
  - No `frame_done`/`underrun`.
  - A subsequent 0x80 is encoded correctly from bit 7.
- T_BIT=8, T0H=2, T1H=6 parameter sweep with 0x0F: high widths are 2,2,2,2,6,6,6,6 within 8-cycle cells.

Source files
------------

// File: rtl/ws2811_stream_encoder.sv
// WS2811/WS2812 single-wire NRZ encoder: byte handshake in, MSB-first timed bit cells out,
// with per-frame byte counting, automatic latch gap and underrun abort.
module ws2811_stream_encoder #(
  parameter int T_BIT           = 16,
  parameter int T0H             = 4,
  parameter int T1H             = 12,
  parameter int LATCH_CYCLES    = 640,
  parameter int BYTES_PER_FRAME = 90
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ws2811,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  if (!(T0H > 0 && T0H < T1H && T1H < T_BIT && LATCH_CYCLES >= 1 && BYTES_PER_FRAME >= 1))
  begin : g_param_check
    $error("ws2811_stream_encoder: illegal timing or frame parameters");
  end

  localparam int CW = $clog2(T_BIT);
  localparam int NW = $clog2(BYTES_PER_FRAME + 1);
  localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

  localparam logic [CW-1:0] CYC_LAST = CW'(T_BIT - 1);
  localparam logic [CW-1:0] HI_ZERO  = CW'(T0H);
  localparam logic [CW-1:0] HI_ONE   = CW'(T1H);
  localparam logic [NW-1:0] NB_FULL  = NW'(BYTES_PER_FRAME);
  localparam logic [LW-1:0] LC_LAST  = LW'(LATCH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t        state;
  logic [7:0]    hold;
  logic          hold_v;
  logic [7:0]    sh;
  logic [CW-1:0] cyc;
  logic [2:0]    bi;
  logic [NW-1:0] nb;
  logic [LW-1:0] lc;
  logic          aborted;

  logic          accept;
  logic          cell_end;
  logic          byte_end;
  logic          frame_full;
  logic          load;
  logic [CW-1:0] cyc_inc;
  logic [CW-1:0] hi_len;
  logic [NW-1:0] nb_inc;

  // Handshake: a byte transfers on every rising edge where in_valid and in_ready are both 1;
  // in_ready depends only on the holding flag, never on in_valid.
  assign in_ready   = ~hold_v;
  assign accept     = in_valid & ~hold_v;

  assign cyc_inc    = cyc + CW'(1);
  assign nb_inc     = nb + NW'(1);
  assign hi_len     = sh[bi] ? HI_ONE : HI_ZERO;
  assign cell_end   = (state == SEND) && (cyc == CYC_LAST);
  assign byte_end   = cell_end && (bi == 3'd0);
  assign frame_full = (nb_inc == NB_FULL);
  assign load       = hold_v && ((state == IDLE) || (byte_end && !frame_full));

  always_ff @(posedge clk) begin
    if (rst) begin
      hold   <= 8'd0;
      hold_v <= 1'b0;
    end else if (accept) begin
      hold   <= in_data;
      hold_v <= 1'b1;
    end else if (load) begin
      hold_v <= 1'b0;
    end
  end

  // ws2811 is registered from the next-cycle counter values, so each cell starts high
  // on the same edge that starts it and the pin never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sh         <= 8'd0;
      cyc        <= '0;
      bi         <= 3'd0;
      nb         <= '0;
      lc         <= '0;
      aborted    <= 1'b0;
      ws2811     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      case (state)
        IDLE: begin
          ws2811 <= 1'b0;
          busy   <= 1'b0;
          lc     <= '0;
          if (hold_v) begin
            sh     <= hold;
            bi     <= 3'd7;
            cyc    <= '0;
            nb     <= '0;
            ws2811 <= 1'b1;
            busy   <= 1'b1;
            state  <= SEND;
          end
        end

        SEND: begin
          if (cyc == CYC_LAST) begin
            cyc <= '0;
            if (bi != 3'd0) begin
              bi     <= bi - 3'd1;
              ws2811 <= 1'b1;
            end else begin
              nb <= nb_inc;
              if (frame_full) begin
                aborted <= 1'b0;
                lc      <= '0;
                ws2811  <= 1'b0;
                state   <= LATCH;
              end else if (hold_v) begin
                sh     <= hold;
                bi     <= 3'd7;
                ws2811 <= 1'b1;
              end else begin
                // Starved mid-frame: latch what the strip already has.
                aborted  <= 1'b1;
                underrun <= 1'b1;
                lc       <= '0;
                ws2811   <= 1'b0;
                state    <= LATCH;
              end
            end
          end else begin
            cyc    <= cyc_inc;
            ws2811 <= (cyc_inc < hi_len);
          end
        end

        LATCH: begin
          ws2811 <= 1'b0;
          if (lc == LC_LAST) begin
            frame_done <= ~aborted;
            busy       <= 1'b0;
            lc         <= '0;
            state      <= IDLE;
          end else begin
            lc <= lc + LW'(1);
          end
        end

        default: begin
          ws2811 <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2811_stream_encoder.sv
// Bench for ws2811_stream_encoder: three parameterisations, waveform captured per cycle and
// compared against a reference built from the bit-cell timing rules.
module tb_ws2811_stream_encoder;

  localparam int N_DUT = 3;
  localparam int LATCH = 640;
  localparam int CFG_TBIT [N_DUT] = '{16, 16, 8};
  localparam int CFG_T0H  [N_DUT] = '{4, 4, 2};
  localparam int CFG_T1H  [N_DUT] = '{12, 12, 6};
  localparam int CFG_BPF  [N_DUT] = '{1, 3, 1};

  logic             clk;
  logic [N_DUT-1:0] rst;
  logic [7:0]       din [N_DUT];
  logic [N_DUT-1:0] vld;
  logic [N_DUT-1:0] rdy;
  logic [N_DUT-1:0] ws;
  logic [N_DUT-1:0] busy;
  logic [N_DUT-1:0] fd;
  logic [N_DUT-1:0] ur;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    ws2811_stream_encoder #(
      .T_BIT(CFG_TBIT[g]), .T0H(CFG_T0H[g]), .T1H(CFG_T1H[g]),
      .LATCH_CYCLES(LATCH), .BYTES_PER_FRAME(CFG_BPF[g])
    ) u_dut (
      .clk(clk), .rst(rst[g]), .in_data(din[g]), .in_valid(vld[g]), .in_ready(rdy[g]),
      .ws2811(ws[g]), .busy(busy[g]), .frame_done(fd[g]), .underrun(ur[g])
    );
  end

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic [7:0] tx_q[$];
  bit q_ws[$], q_busy[$], q_fd[$], q_ur[$], q_acc[$];

  // driver: presents tx_q in order, optionally with random idle gaps
  task automatic drive(input int d, input int gap_max);
    int gap;
    bit got;
    for (int k = 0; k < tx_q.size(); k++) begin
      gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      if (gap > 0) begin
        vld[d] = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      din[d] = tx_q[k];
      vld[d] = 1'b1;
      got = 1'b0;
      for (int w = 0; w < 3000 && !got; w++) begin
        @(negedge clk);
        if (rdy[d]) got = 1'b1;
      end
      check("drive_accept", got, 1);
      @(posedge clk);
      #1;
    end
    vld[d] = 1'b0;
  endtask

  // monitor: records one sample per cycle until busy has been high and then low for 3 cycles
  task automatic monitor(input int d, input int budget);
    bit seen = 1'b0;
    bit done = 1'b0;
    int low_run = 0;
    q_ws.delete(); q_busy.delete(); q_fd.delete(); q_ur.delete(); q_acc.delete();
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      q_ws.push_back(ws[d]);
      q_busy.push_back(busy[d]);
      q_fd.push_back(fd[d]);
      q_ur.push_back(ur[d]);
      q_acc.push_back(vld[d] & rdy[d]);
      if (busy[d]) begin
        seen = 1'b1;
        low_run = 0;
      end else if (seen) begin
        low_run++;
      end
      if (seen && low_run >= 3) done = 1'b1;
    end
    check("monitor_done", done, 1);
  endtask

  // scoreboard: expected waveform derived from the bytes and the cell timing rules
  task automatic analyse(input int d, input string tag);
    int t_bit = CFG_TBIT[d];
    int bpf = CFG_BPF[d];
    int nsent = tx_q.size();
    int nframe = (nsent < bpf) ? nsent : bpf;
    int complete = (nsent >= bpf) ? 1 : 0;
    int send_len = nframe * 8 * t_bit;
    int a0 = -1, r = -1, acc_n = 0, busy_n = 0, busy_first = -1;
    int fd_n = 0, fd_at = -1, ur_n = 0, ur_at = -1, diffs = 0, run = 0, hi;
    bit exp_ws[$];
    int exp_w[$];
    int obs_w[$];
    for (int i = 0; i < q_ws.size(); i++) begin
      if (q_acc[i]) begin acc_n++; if (a0 < 0) a0 = i; end
      if (q_ws[i] && r < 0) r = i;
      if (q_busy[i]) begin busy_n++; if (busy_first < 0) busy_first = i; end
      if (q_fd[i]) begin fd_n++; fd_at = i; end
      if (q_ur[i]) begin ur_n++; ur_at = i; end
    end
    check({tag, " latency"}, r - a0, 2);
    if (r < 0) r = 0;
    for (int k = 0; k < nframe; k++) begin
      for (int b = 7; b >= 0; b--) begin
        hi = tx_q[k][b] ? CFG_T1H[d] : CFG_T0H[d];
        exp_w.push_back(hi);
        for (int j = 0; j < t_bit; j++) exp_ws.push_back(j < hi);
      end
    end
    for (int j = 0; j < LATCH; j++) exp_ws.push_back(1'b0);
    for (int i = 0; i < exp_ws.size(); i++) begin
      if (r + i >= q_ws.size()) diffs++;
      else if (q_ws[r + i] != exp_ws[i]) diffs++;
    end
    check({tag, " wave_diffs"}, diffs, 0);
    for (int i = 0; i < q_ws.size(); i++) begin
      if (q_ws[i]) run++;
      else if (run > 0) begin obs_w.push_back(run); run = 0; end
    end
    if (run > 0) obs_w.push_back(run);
    check({tag, " pulse_count"}, obs_w.size(), exp_w.size());
    for (int i = 0; i < exp_w.size(); i++)
      check($sformatf("%s pulse%0d", tag, i), (i < obs_w.size()) ? obs_w[i] : -1, exp_w[i]);
    check({tag, " busy_cycles"}, busy_n, send_len + LATCH);
    check({tag, " busy_start"}, busy_first, r);
    check({tag, " accepts"}, acc_n, nsent);
    check({tag, " frame_done_count"}, fd_n, complete);
    check({tag, " underrun_count"}, ur_n, 1 - complete);
    if (complete == 1) check({tag, " frame_done_at"}, fd_at, r + send_len + LATCH);
    else check({tag, " underrun_at"}, ur_at, r + send_len);
  endtask

  task automatic run_frame(input int d, input int gap_max, input string tag);
    @(posedge clk);
    #1;
    fork
      drive(d, gap_max);
      monitor(d, 4000);
    join
    analyse(d, tag);
  endtask

  task automatic latch_overlap_test();
    int fd_seen = 0;
    bit got = 1'b0;
    @(posedge clk); #1;
    din[0] = 8'($urandom_range(0, 255));
    vld[0] = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    repeat (8 * CFG_TBIT[0] + 100) @(negedge clk);
    check("latch busy_in_gap", busy[0], 1);
    check("latch ws_low_in_gap", ws[0], 0);
    @(posedge clk); #1;
    din[0] = 8'($urandom_range(0, 255));
    vld[0] = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    @(negedge clk);
    check("latch accept_drops_ready", rdy[0], 0);
    for (int w = 0; w < 2000 && !got; w++) begin
      if (fd[0]) got = 1'b1;
      else @(negedge clk);
    end
    check("latch frame_done_seen", got, 1);
    check("latch ws_at_idle_entry", ws[0], 0);
    @(negedge clk);
    check("latch send_starts ws", ws[0], 1);
    check("latch send_starts busy", busy[0], 1);
    check("latch ready_after_load", rdy[0], 1);
    got = 1'b0;
    for (int w = 0; w < 2000 && !got; w++) begin
      @(negedge clk);
      if (fd[0]) got = 1'b1;
    end
    check("latch second_frame_done", got, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic reset_test();
    int fd_n = 0, ur_n = 0, ws_n = 0, busy_n = 0;
    @(posedge clk); #1;
    din[0] = 8'hFF;
    vld[0] = 1'b1;
    @(posedge clk); #1;
    din[0] = 8'h3C;
    for (int w = 0; w < 50 && vld[0]; w++) begin
      @(negedge clk);
      if (rdy[0]) begin @(posedge clk); #1; vld[0] = 1'b0; end
    end
    vld[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("rst pre busy", busy[0], 1);
    check("rst pre hold_full", rdy[0], 0);
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    @(negedge clk);
    check("rst ws", ws[0], 0);
    check("rst busy", busy[0], 0);
    check("rst ready", rdy[0], 1);
    for (int i = 0; i < 700; i++) begin
      fd_n += fd[0]; ur_n += ur[0]; ws_n += ws[0]; busy_n += busy[0];
      @(negedge clk);
    end
    check("rst no_frame_done", fd_n, 0);
    check("rst no_underrun", ur_n, 0);
    check("rst pending_discarded", ws_n + busy_n, 0);
    tx_q = '{8'h80};
    run_frame(0, 0, "after_rst_80");
  endtask

  initial begin
    int d, n;
    rst = '1;
    vld = '0;
    for (int i = 0; i < N_DUT; i++) din[i] = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = '0;
    @(negedge clk);
    for (int i = 0; i < N_DUT; i++) begin
      check($sformatf("reset%0d ws", i), ws[i], 0);
      check($sformatf("reset%0d busy", i), busy[i], 0);
      check($sformatf("reset%0d frame_done", i), fd[i], 0);
      check($sformatf("reset%0d underrun", i), ur[i], 0);
      check($sformatf("reset%0d ready", i), rdy[i], 1);
    end

    tx_q = '{8'hA5};
    run_frame(0, 0, "a5");
    tx_q = '{8'hFF, 8'h00, 8'h81};
    run_frame(1, 0, "gapless3");
    tx_q = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
    run_frame(1, 0, "underrun2");
    tx_q = '{8'h0F};
    run_frame(2, 0, "tbit8_0f");

    latch_overlap_test();
    reset_test();

    for (int it = 0; it < 6; it++) begin
      d = $urandom_range(0, N_DUT - 1);
      n = $urandom_range(1, CFG_BPF[d]);
      tx_q.delete();
      for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom_range(0, 255)));
      run_frame(d, 20, $sformatf("rand%0d_dut%0d", it, d));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
